// File: rtl/trap_pkg.sv
// Shared trap definitions: interrupt cause codes, mip/mie bit positions,
// the request FSM encoding and the fixed-priority pick.
package trap_pkg;

    localparam logic [3:0] IRQ_MSI = 4'd3;
    localparam logic [3:0] IRQ_MTI = 4'd7;
    localparam logic [3:0] IRQ_MEI = 4'd11;

    localparam int MSIP_BIT = 3;
    localparam int MTIP_BIT = 7;
    localparam int MEIP_BIT = 11;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        IN_TRAP = 2'd2
    } irq_state_e;

    // Fixed priority MEI > MSI > MTI; only meaningful when eligible != 0.
    function automatic logic [3:0] irq_pick(input logic [63:0] eligible);
        if (eligible[MEIP_BIT]) return IRQ_MEI;
        if (eligible[MSIP_BIT]) return IRQ_MSI;
        return IRQ_MTI;
    endfunction

endpackage

// File: rtl/irq_controller_if.sv
// CSR/trap-handler side bundle of the interrupt controller. The master drives
// writes, enables and handshakes; the slave (irq_controller) returns state.
interface irq_controller_if;

    logic        ext_irq;
    logic        msip_we;
    logic        msip_wdata;
    logic        mtime_we;
    logic        mtimecmp_we;
    logic [63:0] wdata;
    logic [63:0] mie;
    logic        mstatus_mie;
    logic        exc_en;
    logic        trap_taken;
    logic        mret;
    logic        irq_en;
    logic [3:0]  irq_code;
    logic [63:0] irq_val;
    logic [63:0] mip;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;

    modport master (
        output ext_irq, msip_we, msip_wdata, mtime_we, mtimecmp_we, wdata,
               mie, mstatus_mie, exc_en, trap_taken, mret,
        input  irq_en, irq_code, irq_val, mip, mtime, mtimecmp
    );

    modport slave (
        input  ext_irq, msip_we, msip_wdata, mtime_we, mtimecmp_we, wdata,
               mie, mstatus_mie, exc_en, trap_taken, mret,
        output irq_en, irq_code, irq_val, mip, mtime, mtimecmp
    );

endinterface

// File: rtl/irq_timer.sv
// Machine timer: prescaler, 64-bit mtime/mtimecmp and the registered MTIP compare.
module irq_timer #(
    parameter int unsigned TICK_DIV = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mtime_we,
    input  logic        mtimecmp_we,
    input  logic [63:0] wdata,
    output logic [63:0] mtime,
    output logic [63:0] mtimecmp,
    output logic        mtip
);

    logic [15:0] presc;
    logic        tick;

    assign tick = (presc == 16'(TICK_DIV - 1));

    // NOTE: sequential state uses non-blocking assignments only, so every
    // right-hand side below sees the value from before this edge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            presc    <= '0;
            mtime    <= '0;
            mtimecmp <= '1;
            mtip     <= 1'b0;
        end else begin
            presc <= tick ? '0 : presc + 16'd1;
            // A write on a tick cycle wins and that increment is dropped.
            if (mtime_we)
                mtime <= wdata;
            else if (tick)
                mtime <= mtime + 64'd1;
            if (mtimecmp_we)
                mtimecmp <= wdata;
            mtip <= (mtime >= mtimecmp);
        end
    end

endmodule

// File: rtl/irq_controller.sv
// Machine-mode interrupt source block: forms mip, masks with mie/mstatus.MIE,
// picks by priority and holds one request until trap_taken, blocking until mret.
module irq_controller
    import trap_pkg::*;
#(
    parameter int unsigned TICK_DIV    = 16,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic             clk,
    input logic             rst,
    irq_controller_if.slave bus
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   meip_q;
    logic                   msip_q;
    logic                   mtip;
    logic [63:0]            mip_w;
    logic [63:0]            eligible;
    irq_state_e             state;
    logic                   irq_en_q;
    logic [3:0]             irq_code_q;

    irq_timer #(.TICK_DIV(TICK_DIV)) u_timer (
        .clk         (clk),
        .rst         (rst),
        .mtime_we    (bus.mtime_we),
        .mtimecmp_we (bus.mtimecmp_we),
        .wdata       (bus.wdata),
        .mtime       (bus.mtime),
        .mtimecmp    (bus.mtimecmp),
        .mtip        (mtip)
    );

    // NOTE: default every bit first so no path through the block leaves
    // mip_w unassigned, which would infer a latch.
    always_comb begin
        mip_w           = '0;
        mip_w[MSIP_BIT] = msip_q;
        mip_w[MTIP_BIT] = mtip;
        mip_w[MEIP_BIT] = meip_q;
    end

    assign eligible     = mip_w & bus.mie & {64{bus.mstatus_mie}};
    assign bus.mip      = mip_w;
    assign bus.irq_en   = irq_en_q;
    assign bus.irq_code = irq_code_q;
    assign bus.irq_val  = '0;

    // ext_irq is asynchronous; meip_q adds the mip register after the chain.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q <= '0;
            meip_q <= 1'b0;
            msip_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], bus.ext_irq};
            meip_q <= sync_q[SYNC_STAGES-1];
            if (bus.msip_we)
                msip_q <= bus.msip_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            irq_en_q   <= 1'b0;
            irq_code_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (eligible != '0 && !bus.exc_en) begin
                        state      <= REQ;
                        irq_en_q   <= 1'b1;
                        irq_code_q <= irq_pick(eligible);
                    end
                end
                // The request is never retracted or re-coded once issued.
                REQ: begin
                    if (bus.trap_taken) begin
                        state    <= IN_TRAP;
                        irq_en_q <= 1'b0;
                    end
                end
                IN_TRAP: begin
                    if (bus.mret)
                        state <= IDLE;
                end
                default: begin
                    state    <= IDLE;
                    irq_en_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller: directed scenarios plus a randomized
// run compared cycle by cycle against a behavioural model.
module tb_irq_controller;

    localparam int unsigned TICK_DIV    = 4;
    localparam int unsigned SYNC_STAGES = 2;
    localparam logic [63:0] ALL_ONES    = 64'hFFFF_FFFF_FFFF_FFFF;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_pass  = 0;
    int   n_total = 0;

    irq_controller_if bus ();

    irq_controller #(.TICK_DIV(TICK_DIV), .SYNC_STAGES(SYNC_STAGES)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.ext_irq     = 1'b0;
        bus.msip_we     = 1'b0;
        bus.msip_wdata  = 1'b0;
        bus.mtime_we    = 1'b0;
        bus.mtimecmp_we = 1'b0;
        bus.wdata       = '0;
        bus.mie         = '0;
        bus.mstatus_mie = 1'b0;
        bus.exc_en      = 1'b0;
        bus.trap_taken  = 1'b0;
        bus.mret        = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
    endtask

    task automatic expect_irq(input string name, input logic en, input logic [3:0] code);
        n_total++;
        if (bus.irq_en !== en)
            $display("FAIL %s irq_en: got %0b want %0b", name, bus.irq_en, en);
        else
            n_pass++;
        if (en) begin
            n_total++;
            if (bus.irq_code !== code)
                $display("FAIL %s irq_code: got %0d want %0d", name, bus.irq_code, code);
            else
                n_pass++;
        end
    endtask

    task automatic test_reset();
        do_reset();
        expect_irq("reset", 1'b0, 4'd0);
        n_total++;
        if (bus.irq_code !== 4'd0) $display("FAIL reset_code: got %0d want 0", bus.irq_code); else n_pass++;
        n_total++;
        if (bus.irq_val !== 64'd0) $display("FAIL reset_val: got %h want 0", bus.irq_val); else n_pass++;
        n_total++;
        if (bus.mip !== 64'd0) $display("FAIL reset_mip: got %h want 0", bus.mip); else n_pass++;
        n_total++;
        if (bus.mtime !== 64'd0) $display("FAIL reset_mtime: got %h want 0", bus.mtime); else n_pass++;
        n_total++;
        if (bus.mtimecmp !== ALL_ONES) $display("FAIL reset_mtimecmp: got %h want %h", bus.mtimecmp, ALL_ONES); else n_pass++;
    endtask

    task automatic test_timer_irq();
        do_reset();
        bus.mie         = 64'd1 << 7;
        bus.mstatus_mie = 1'b1;
        bus.mtimecmp_we = 1'b1;
        bus.wdata       = 64'd3;
        step();
        bus.mtimecmp_we = 1'b0;
        n_total++;
        if (bus.mtimecmp !== 64'd3) $display("FAIL timer_cmp_write: got %h want 3", bus.mtimecmp); else n_pass++;
        for (int i = 0; i < 40 && bus.mtime !== 64'd3; i++) step();
        n_total++;
        if (bus.mtime !== 64'd3) $display("FAIL timer_reach3: got %h want 3", bus.mtime); else n_pass++;
        n_total++;
        if (bus.mip[7] !== 1'b0) $display("FAIL timer_mtip_lag: got %0b want 0", bus.mip[7]); else n_pass++;
        step();
        n_total++;
        if (bus.mip[7] !== 1'b1) $display("FAIL timer_mtip_set: got %0b want 1", bus.mip[7]); else n_pass++;
        expect_irq("timer_before_req", 1'b0, 4'd0);
        step();
        expect_irq("timer_req", 1'b1, 4'd7);
        bus.trap_taken = 1'b1;
        step();
        bus.trap_taken = 1'b0;
        expect_irq("timer_ack", 1'b0, 4'd0);
    endtask

    task automatic test_priority();
        do_reset();
        bus.mie         = (64'd1 << 3) | (64'd1 << 7) | (64'd1 << 11);
        bus.msip_we     = 1'b1;
        bus.msip_wdata  = 1'b1;
        bus.mtimecmp_we = 1'b1;
        bus.wdata       = 64'd0;
        step();
        bus.msip_we     = 1'b0;
        bus.mtimecmp_we = 1'b0;
        step();
        n_total++;
        if (bus.mip !== 64'h88) $display("FAIL prio_mip_msi_mti: got %h want 88", bus.mip); else n_pass++;
        bus.ext_irq = 1'b1;
        step();
        step();
        n_total++;
        if (bus.mip[11] !== 1'b0) $display("FAIL prio_meip_early: got %0b want 0", bus.mip[11]); else n_pass++;
        step();
        n_total++;
        if (bus.mip[11] !== 1'b1) $display("FAIL prio_meip_latency: got %0b want 1", bus.mip[11]); else n_pass++;
        bus.mstatus_mie = 1'b1;
        step();
        expect_irq("prio_first_mei", 1'b1, 4'd11);
        bus.trap_taken = 1'b1;
        bus.ext_irq    = 1'b0;
        step();
        bus.trap_taken = 1'b0;
        expect_irq("prio_mei_ack", 1'b0, 4'd0);
        step();
        step();
        step();
        bus.mret = 1'b1;
        step();
        bus.mret = 1'b0;
        expect_irq("prio_mret_edge", 1'b0, 4'd0);
        step();
        expect_irq("prio_then_msi", 1'b1, 4'd3);
    endtask

    task automatic test_exc_en();
        do_reset();
        bus.mie         = 64'd1 << 3;
        bus.mstatus_mie = 1'b1;
        bus.msip_we     = 1'b1;
        bus.msip_wdata  = 1'b1;
        step();
        bus.msip_we = 1'b0;
        bus.exc_en  = 1'b1;
        step();
        bus.exc_en = 1'b0;
        expect_irq("exc_suppress", 1'b0, 4'd0);
        step();
        expect_irq("exc_next_cycle", 1'b1, 4'd3);
    endtask

    task automatic test_trap_block();
        do_reset();
        bus.mie         = (64'd1 << 3) | (64'd1 << 11);
        bus.mstatus_mie = 1'b1;
        bus.msip_we     = 1'b1;
        bus.msip_wdata  = 1'b1;
        step();
        bus.msip_we = 1'b0;
        step();
        expect_irq("block_msi_req", 1'b1, 4'd3);
        bus.trap_taken = 1'b1;
        bus.msip_we    = 1'b1;
        bus.msip_wdata = 1'b0;
        step();
        bus.trap_taken = 1'b0;
        bus.msip_we    = 1'b0;
        bus.ext_irq    = 1'b1;
        expect_irq("block_ack", 1'b0, 4'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            expect_irq($sformatf("block_in_trap_%0d", i), 1'b0, 4'd0);
        end
        bus.mret = 1'b1;
        step();
        bus.mret = 1'b0;
        expect_irq("block_mret_edge", 1'b0, 4'd0);
        step();
        expect_irq("block_mei_after_mret", 1'b1, 4'd11);
    endtask

    task automatic test_mtime_wrap();
        do_reset();
        step();
        step();
        step();
        bus.mtime_we = 1'b1;
        bus.wdata    = ALL_ONES;
        step();
        bus.mtime_we = 1'b0;
        n_total++;
        if (bus.mtime !== ALL_ONES) $display("FAIL wrap_write_wins: got %h want %h", bus.mtime, ALL_ONES); else n_pass++;
        step();
        step();
        step();
        n_total++;
        if (bus.mtime !== ALL_ONES) $display("FAIL wrap_hold: got %h want %h", bus.mtime, ALL_ONES); else n_pass++;
        step();
        n_total++;
        if (bus.mtime !== 64'd0) $display("FAIL wrap_to_zero: got %h want 0", bus.mtime); else n_pass++;
        bus.mie         = 64'd1 << 3;
        bus.mstatus_mie = 1'b1;
        bus.msip_we     = 1'b1;
        bus.msip_wdata  = 1'b1;
        step();
        bus.msip_we = 1'b0;
        step();
        expect_irq("rst_mid_req_before", 1'b1, 4'd3);
        rst = 1'b0;
        step();
        expect_irq("rst_mid_req_after", 1'b0, 4'd0);
        n_total++;
        if (bus.mip !== 64'd0) $display("FAIL rst_mid_req_mip: got %h want 0", bus.mip); else n_pass++;
        rst = 1'b1;
    endtask

    function automatic logic [3:0] ref_pick(input logic [63:0] e);
        if (e[11]) return 4'd11;
        if (e[3])  return 4'd3;
        return 4'd7;
    endfunction

    task automatic test_random();
        logic [63:0] m_mtime, m_cmp, m_mip, elig, n_mtime, n_cmp;
        logic        m_msip, m_mtip, m_meip, m_req, m_trap;
        logic [3:0]  m_code;
        logic        hist[$];
        int          k;

        do_reset();
        m_mtime = '0;
        m_cmp   = ALL_ONES;
        m_msip  = 1'b0;
        m_mtip  = 1'b0;
        m_meip  = 1'b0;
        m_req   = 1'b0;
        m_trap  = 1'b0;
        m_code  = '0;
        k       = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if ($urandom_range(0, 7) == 0) bus.ext_irq = ~bus.ext_irq;
            bus.msip_we     = ($urandom_range(0, 5) == 0);
            bus.msip_wdata  = 1'($urandom_range(0, 1));
            bus.mtime_we    = ($urandom_range(0, 19) == 0);
            bus.mtimecmp_we = ($urandom_range(0, 9) == 0);
            bus.wdata       = bus.mtime_we && $urandom_range(0, 1) ? 64'hFFFF_FFFF_FFFF_FFFD
                                                                   : 64'($urandom_range(0, 40));
            bus.mie         = ({63'd0, 1'($urandom_range(0, 1))} << 3) |
                              ({63'd0, 1'($urandom_range(0, 1))} << 7) |
                              ({63'd0, 1'($urandom_range(0, 1))} << 11);
            bus.mstatus_mie = ($urandom_range(0, 3) != 0);
            bus.exc_en      = ($urandom_range(0, 4) == 0);
            bus.trap_taken  = ($urandom_range(0, 2) == 0);
            bus.mret        = ($urandom_range(0, 3) == 0);

            // Model of what the coming edge must produce, from pre-edge values.
            m_mip = (64'(m_msip) << 3) | (64'(m_mtip) << 7) | (64'(m_meip) << 11);
            elig  = m_mip & bus.mie & {64{bus.mstatus_mie}};
            k++;
            m_mtip  = (m_mtime >= m_cmp);
            n_mtime = bus.mtime_we ? bus.wdata : ((k % TICK_DIV) == 0 ? m_mtime + 64'd1 : m_mtime);
            n_cmp   = bus.mtimecmp_we ? bus.wdata : m_cmp;
            m_mtime = n_mtime;
            m_cmp   = n_cmp;
            if (bus.msip_we) m_msip = bus.msip_wdata;
            hist.push_back(bus.ext_irq);
            m_meip = (hist.size() > SYNC_STAGES) ? hist[hist.size() - 1 - SYNC_STAGES] : 1'b0;
            if (m_trap) begin
                if (bus.mret) m_trap = 1'b0;
            end else if (m_req) begin
                if (bus.trap_taken) begin
                    m_req  = 1'b0;
                    m_trap = 1'b1;
                end
            end else if (elig != 0 && !bus.exc_en) begin
                m_req  = 1'b1;
                m_code = ref_pick(elig);
            end
            m_mip = (64'(m_msip) << 3) | (64'(m_mtip) << 7) | (64'(m_meip) << 11);

            step();
            n_total++;
            if (bus.irq_en !== m_req) $display("FAIL rand_irq_en cyc %0d: got %0b want %0b", cyc, bus.irq_en, m_req); else n_pass++;
            n_total++;
            if (bus.irq_code !== m_code) $display("FAIL rand_code cyc %0d: got %0d want %0d", cyc, bus.irq_code, m_code); else n_pass++;
            n_total++;
            if (bus.mip !== m_mip) $display("FAIL rand_mip cyc %0d: got %h want %h", cyc, bus.mip, m_mip); else n_pass++;
            n_total++;
            if (bus.mtime !== m_mtime) $display("FAIL rand_mtime cyc %0d: got %h want %h", cyc, bus.mtime, m_mtime); else n_pass++;
            n_total++;
            if (bus.mtimecmp !== m_cmp) $display("FAIL rand_mtimecmp cyc %0d: got %h want %h", cyc, bus.mtimecmp, m_cmp); else n_pass++;
            n_total++;
            if (bus.irq_val !== 64'd0) $display("FAIL rand_irq_val cyc %0d: got %h want 0", cyc, bus.irq_val); else n_pass++;
        end
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_timer_irq();
        test_priority();
        test_exc_en();
        test_trap_block();
        test_mtime_wrap();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not complete within limit");
        $fatal(1);
    end

endmodule
